// File: rtl/mc_main_fsm_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath:
// opcode in, per-cycle enables and mux selects out.
interface mc_main_fsm_if;
    logic [5:0] op;
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op,
        output pcwrite, branch, irwrite, regwrite, memwrite, iord, memtoreg,
               regdst, alusrca, alusrcb, pcsrc, aluop, illegal_op, state
    );

    modport slave (
        output op,
        input  pcwrite, branch, irwrite, regwrite, memwrite, iord, memtoreg,
               regdst, alusrca, alusrcb, pcsrc, aluop, illegal_op, state
    );
endinterface

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle MIPS datapath: Moore machine sequencing
// one instruction at a time; all outputs are held at zero while reset is low.
module mc_main_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic          clk,
    input  logic          reset,
    mc_main_fsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal_op;
    logic       op_known;

    assign op_known = (bus.op == OP_RTYPE) || (bus.op == OP_LW)   ||
                      (bus.op == OP_SW)    || (bus.op == OP_BEQ)  ||
                      (bus.op == OP_ADDI)  || (bus.op == OP_J);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                if      (bus.op == OP_LW || bus.op == OP_SW) state_d = MEMADR;
                else if (bus.op == OP_RTYPE)                 state_d = EXECUTE;
                else if (bus.op == OP_BEQ)                   state_d = BRANCH;
                else if (bus.op == OP_ADDI)                  state_d = ADDIEX;
                else if (bus.op == OP_J)                     state_d = JUMP;
                else                                         state_d = FETCH;
            end
            MEMADR: begin
                // IR is stable through the instruction, so op still selects load vs store
                if      (bus.op == OP_LW) state_d = MEMRD;
                else if (bus.op == OP_SW) state_d = MEMWR;
                else                      state_d = FETCH;
            end
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        branch     = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        // Gating on reset keeps PC/IR writes off during the async reset window
        if (reset) begin
            case (state_q)
                FETCH: begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    alusrcb = 2'b01;
                end
                DECODE: begin
                    alusrcb    = 2'b11;
                    illegal_op = ~op_known;
                end
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD:   iord = 1'b1;
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                EXECUTE: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                ADDIWB:  regwrite = 1'b1;
                JUMP: begin
                    pcwrite = 1'b1;
                    pcsrc   = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign bus.pcwrite    = pcwrite;
    assign bus.branch     = branch;
    assign bus.irwrite    = irwrite;
    assign bus.regwrite   = regwrite;
    assign bus.memwrite   = memwrite;
    assign bus.iord       = iord;
    assign bus.memtoreg   = memtoreg;
    assign bus.regdst     = regdst;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.aluop      = aluop;
    assign bus.illegal_op = illegal_op;
    assign bus.state      = state_q;

endmodule
